brtgt_arbiter: RTL and testbench



---
 rtl/brtgt_pkg.sv | 18 +
 rtl/brtgt_arbiter_rr_pick2.sv | 33 +++
 rtl/brtgt_arbiter.sv | 100 ++++++++++
 tb/tb_brtgt_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/brtgt_pkg.sv
// Shared types and defaults for the branch-target arbiter.
`default_nettype none

package brtgt_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int IMM_W_DEF = 13;

  typedef logic port_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/brtgt_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin / fixed-priority picker.
`default_nettype none

module rr_pick2
  import brtgt_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  port_id_t   last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant,
  output port_id_t   grant_id
);

  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (valid0 && valid1) begin
      // On a tie the port that did not win last time goes next.
      grant_id = (fixed_prio || (last_grant == 1'b0)) ? 1'b1 : 1'b0;
      grant    = grant_id ? 2'b10 : 2'b01;
    end else if (valid0) begin
      grant    = 2'b01;
      grant_id = 1'b0;
    end else if (valid1) begin
      grant    = 2'b10;
      grant_id = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/brtgt_arbiter.sv
// brtgt_arbiter: shared PC + sign-extended-immediate adder, two requesters, one-entry output buffer.
// Optional OUT_MISALIGN output when BRTGT_ALIGN_CHECK_EN is defined.
`default_nettype none

module brtgt_arbiter
  import brtgt_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int IMM_W      = IMM_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  input  logic [XLEN-1:0]  REQ0_PC,
  input  logic [IMM_W-1:0] REQ0_IMM,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [XLEN-1:0]  REQ1_PC,
  input  logic [IMM_W-1:0] REQ1_IMM,
  output logic             REQ1_READY,
  output logic             OUT_VALID,
  output logic [XLEN-1:0]  OUT_TARGET,
  output logic             OUT_ID,
  input  logic             OUT_READY
`ifdef BRTGT_ALIGN_CHECK_EN
  , output logic           OUT_MISALIGN
`endif
);

  state_t          state, state_next;
  port_id_t        last_grant;
  logic [1:0]      grant;
  port_id_t        grant_id;
  logic            can_accept;
  logic            handshake;
  logic [XLEN-1:0] sel_pc;
  logic [IMM_W-1:0] sel_imm;
  logic [XLEN-1:0] target_sum;

  rr_pick2 u_pick (
    .valid0     (REQ0_VALID),
    .valid1     (REQ1_VALID),
    .last_grant (last_grant),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign can_accept = (state == EMPTY) || OUT_READY;
  // Requests seen while reset is asserted are never accepted.
  assign REQ0_READY = !RST && can_accept && grant[0];
  assign REQ1_READY = !RST && can_accept && grant[1];
  assign handshake  = REQ0_READY || REQ1_READY;

  assign sel_pc     = grant_id ? REQ1_PC  : REQ0_PC;
  assign sel_imm    = grant_id ? REQ1_IMM : REQ0_IMM;
  assign target_sum = sel_pc + {{(XLEN-IMM_W){sel_imm[IMM_W-1]}}, sel_imm};

  always_comb begin
    state_next = state;
    if (handshake)
      state_next = FULL;
    else if ((state == FULL) && OUT_READY)
      state_next = EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      state <= EMPTY;
    else
      state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant <= 1'b1;
      OUT_TARGET <= '0;
      OUT_ID     <= 1'b0;
    end else if (handshake) begin
      last_grant <= grant_id;
      OUT_TARGET <= target_sum;
      OUT_ID     <= grant_id;
    end
  end

`ifdef BRTGT_ALIGN_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RST)
      OUT_MISALIGN <= 1'b0;
    else if (handshake)
      OUT_MISALIGN <= target_sum[1] | target_sum[0];
  end
`endif

  assign OUT_VALID = (state == FULL);

endmodule

`default_nettype wire

// File: tb/tb_brtgt_arbiter.sv
// Randomized + directed bench for brtgt_arbiter against a behavioural model.
`default_nettype none

module tb_brtgt_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, v1, ordy;
  logic [31:0] pc0, pc1;
  logic [12:0] imm0, imm1;
  logic        r0, r1, ov, oid;
  logic [31:0] otgt;
  logic        fr0, fr1, fov, foid;
  logic [31:0] ftgt;
`ifdef BRTGT_ALIGN_CHECK_EN
  logic        omis, fmis;
`endif

  brtgt_arbiter #(.XLEN(32), .IMM_W(13), .FIXED_PRIO(0)) dut (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(v0), .REQ0_PC(pc0), .REQ0_IMM(imm0), .REQ0_READY(r0),
    .REQ1_VALID(v1), .REQ1_PC(pc1), .REQ1_IMM(imm1), .REQ1_READY(r1),
    .OUT_VALID(ov), .OUT_TARGET(otgt), .OUT_ID(oid), .OUT_READY(ordy)
`ifdef BRTGT_ALIGN_CHECK_EN
    , .OUT_MISALIGN(omis)
`endif
  );

  // Second instance: fixed priority, both ports always requesting.
  brtgt_arbiter #(.XLEN(32), .IMM_W(13), .FIXED_PRIO(1)) dut_fp (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(1'b1), .REQ0_PC(32'h0000_0020), .REQ0_IMM(13'h0002), .REQ0_READY(fr0),
    .REQ1_VALID(1'b1), .REQ1_PC(32'h0000_0040), .REQ1_IMM(13'h0004), .REQ1_READY(fr1),
    .OUT_VALID(fov), .OUT_TARGET(ftgt), .OUT_ID(foid), .OUT_READY(1'b1)
`ifdef BRTGT_ALIGN_CHECK_EN
    , .OUT_MISALIGN(fmis)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model, index 0 = round-robin DUT, 1 = fixed-priority DUT.
  bit          m_valid [2];
  logic [31:0] m_tgt   [2];
  bit          m_id    [2];
  bit          m_last  [2];
  int          exp_w   [2];
  bit          s_r0, s_r1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] target(logic [31:0] pc, logic [12:0] imm);
    longint s;
    s = longint'(imm);
    if (imm >= 13'd4096) s = s - 8192;
    return 32'((longint'(pc) + s) & 64'hFFFF_FFFF);
  endfunction

  function automatic int winner(int k, bit a, bit b);
    if (a && b) begin
      if (k == 1) return 1;
      return (m_last[k] == 1'b1) ? 0 : 1;
    end
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic compare(int k, bit a, bit b, bit o_rdy, bit ra, bit rb,
                         bit va, logic [31:0] ta, bit ia, bit misa);
    bit can;
    int w;
    can = !m_valid[k] || o_rdy;
    w   = (rst || !can) ? -1 : winner(k, a, b);
    exp_w[k] = w;
    chk(k ? "fp_ready0" : "ready0", longint'(ra), longint'(w == 0));
    chk(k ? "fp_ready1" : "ready1", longint'(rb), longint'(w == 1));
    chk(k ? "fp_out_valid" : "out_valid", longint'(va), longint'(m_valid[k]));
    chk(k ? "fp_out_target" : "out_target", longint'(ta), longint'(m_tgt[k]));
    chk(k ? "fp_out_id" : "out_id", longint'(ia), longint'(m_id[k]));
`ifdef BRTGT_ALIGN_CHECK_EN
    chk(k ? "fp_misalign" : "misalign", longint'(misa), longint'(m_tgt[k][1:0] != 2'b00));
`else
    if (misa) chk("misalign_absent", 1, 0);
`endif
  endtask

  task automatic update(int k, bit r, bit o_rdy, logic [31:0] p0, logic [12:0] i0,
                        logic [31:0] p1, logic [12:0] i1);
    if (r) begin
      m_valid[k] = 0; m_tgt[k] = '0; m_id[k] = 0; m_last[k] = 1;
    end else if (exp_w[k] >= 0) begin
      m_valid[k] = 1;
      m_tgt[k]   = (exp_w[k] == 1) ? target(p1, i1) : target(p0, i0);
      m_id[k]    = (exp_w[k] == 1);
      m_last[k]  = (exp_w[k] == 1);
    end else if (m_valid[k] && o_rdy) begin
      m_valid[k] = 0;
    end
  endtask

  // One cycle: inputs already driven after negedge; compare, take the edge, advance the model.
  task automatic step();
    bit c_rst, c_ordy;
    logic [31:0] c_pc0, c_pc1;
    logic [12:0] c_imm0, c_imm1;
    bit ma, mb;
    #1;
    ma = 1'b0; mb = 1'b0;
`ifdef BRTGT_ALIGN_CHECK_EN
    ma = omis; mb = fmis;
`endif
    compare(0, v0, v1, ordy, r0, r1, ov, otgt, oid, ma);
    compare(1, 1'b1, 1'b1, 1'b1, fr0, fr1, fov, ftgt, foid, mb);
    s_r0 = r0; s_r1 = r1;
    c_rst = rst; c_ordy = ordy;
    c_pc0 = pc0; c_pc1 = pc1; c_imm0 = imm0; c_imm1 = imm1;
    @(posedge clk);
    update(0, c_rst, c_ordy, c_pc0, c_imm0, c_pc1, c_imm1);
    update(1, c_rst, 1'b1, 32'h20, 13'h0002, 32'h40, 13'h0004);
    @(negedge clk);
  endtask

  task automatic req(int p, logic [31:0] pc, logic [12:0] imm);
    if (p == 0) begin v0 = 1; pc0 = pc; imm0 = imm; end
    else        begin v1 = 1; pc1 = pc; imm1 = imm; end
  endtask

  initial begin
    logic [31:0] held_t;
    bit          held_i;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_tgt[k] = '0; m_id[k] = 0; m_last[k] = 1; exp_w[k] = -1;
    end
    rst = 1; v0 = 0; v1 = 0; ordy = 1;
    pc0 = '0; pc1 = '0; imm0 = '0; imm1 = '0;
    @(negedge clk);
    req(0, 32'h0000_0100, 13'h0010);   // request during reset must not be accepted
    step(); step();
    chk("lit_rst_ready0", s_r0, 0);
    rst = 0;
    chk("lit_rst_valid", ov, 0);
    chk("lit_rst_target", otgt, 0);

    // Single request, latency 1
    step();
    chk("lit_single_ready0", s_r0, 1);
    v0 = 0;
    chk("lit_single_target", otgt, 32'h0000_0110);
    chk("lit_single_id", oid, 0);

    req(1, 32'h0000_0008, 13'h1FF8); step(); v1 = 0;
    chk("lit_neg_target", otgt, 32'h0000_0000);
    chk("lit_neg_id", oid, 1);
    req(1, 32'hFFFF_FFFC, 13'h0008); step(); v1 = 0;
    chk("lit_wrap_target", otgt, 32'h0000_0004);
    req(0, 32'h0000_2000, 13'h1000); step(); v0 = 0;
    chk("lit_min_imm", otgt, 32'h0000_1000);
    req(0, 32'h0000_0000, 13'h0FFF); step(); v0 = 0;
    chk("lit_max_imm", otgt, 32'h0000_0FFF);

    // Tie: last grant was port 0, so alternation starts with port 1
    req(0, 32'h1000, 13'h0); req(1, 32'h2000, 13'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lit_tie_id", oid, (i % 2 == 0) ? 1 : 0);
    end

    // Backpressure with both ports valid
    ordy = 0;
    held_t = otgt; held_i = oid;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_bp_ready", {s_r0, s_r1}, 0);
      chk("lit_bp_target", otgt, held_t);
      chk("lit_bp_id", oid, held_i);
    end
    ordy = 1; step();
    chk("lit_bp_release_valid", ov, 1);
    chk("lit_bp_release_id", oid, !held_i);

    // Reset while full and stalled
    ordy = 0; step();
    rst = 1; step(); rst = 0;
    chk("lit_midrst_valid", ov, 0);
    ordy = 1; step();
    chk("lit_midrst_tie_id", oid, 0);
    v0 = 0; v1 = 0; step();

`ifdef BRTGT_ALIGN_CHECK_EN
    req(0, 32'h100, 13'h0002); step(); v0 = 0;
    chk("lit_mis_target", otgt, 32'h0000_0102);
    chk("lit_mis_1", omis, 1);
    req(0, 32'h100, 13'h0004); step(); v0 = 0;
    chk("lit_mis_0", omis, 0);
`endif

    // Randomized phase: requesters hold VALID/PC/IMM until accepted
    for (int n = 0; n < 3000; n++) begin
      if (!v0 && ($urandom_range(0, 2) != 0))
        req(0, $urandom, 13'($urandom));
      if (!v1 && ($urandom_range(0, 2) != 0))
        req(1, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : $urandom, 13'($urandom));
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 60) == 0);
      step();
      if (s_r0) v0 = 0;
      if (s_r1) v1 = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
